// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the memory-port arbiter state encoding.
package cpu_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_IF_WAIT = 3'd1,
        ARB_DM_WAIT = 3'd2,
        ARB_IF_RESP = 3'd3,
        ARB_DM_RESP = 3'd4
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants issued while a fetch is left waiting.
module arb_starve_ctr #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory:
// request, wait for mem_ready, then a one-cycle response per access.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_cap_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              drop_q;
    logic              starve_max;
    logic              fetch_ok;
    logic              grant_dm;
    logic              grant_if;

    assign fetch_ok = if_req && !if_flush;
    assign grant_dm = (state_q == ARB_IDLE) && dm_req && !(starve_max && fetch_ok);
    assign grant_if = (state_q == ARB_IDLE) && fetch_ok && !grant_dm;

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (grant_dm && if_req),
        .clr    (grant_if || !if_req),
        .at_max (starve_max)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_dm) begin
                    state_d = ARB_DM_WAIT;
                end else if (grant_if) begin
                    state_d = ARB_IF_WAIT;
                end
            end
            ARB_IF_WAIT: if (mem_ready) state_d = ARB_IF_RESP;
            ARB_DM_WAIT: if (mem_ready) state_d = ARB_DM_RESP;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_cap_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_dm) begin
                addr_q  <= dm_addr;
                we_q    <= dm_we;
                wdata_q <= dm_wdata;
            end else if (grant_if) begin
                addr_q <= if_addr;
                we_q   <= 1'b0;
            end
            if (state_q == ARB_IF_WAIT && mem_ready) begin
                if_cap_q <= mem_rdata;
            end
            // Writes leave the previous load value in place.
            if (state_q == ARB_DM_WAIT && mem_ready && !we_q) begin
                dm_rdata_q <= mem_rdata;
            end
            if (if_valid) begin
                if_rdata_q <= if_cap_q;
            end
            if (state_d == ARB_IDLE) begin
                drop_q <= 1'b0;
            end else if ((state_q == ARB_IF_WAIT || state_q == ARB_IF_RESP) && if_flush) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign mem_en    = (state_q == ARB_IF_WAIT) || (state_q == ARB_DM_WAIT);
    assign mem_we    = (state_q == ARB_DM_WAIT) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flush arriving in the response cycle itself must still hide the word.
    assign if_valid = (state_q == ARB_IF_RESP) && !drop_q && !if_flush;
    assign dm_valid = (state_q == ARB_DM_RESP);
    assign if_rdata = if_valid ? if_cap_q : if_rdata_q;
    assign dm_rdata = dm_rdata_q;

    assign if_stall = if_req && !if_valid && !if_flush;
    assign dm_stall = dm_req && !dm_valid;

endmodule
